// File: rtl/load_store_unit_if.sv
// Core-side request/response bundle of the load/store unit.
// slave = LSU view, master = core (memory stage) view.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport slave (
    input  req_valid, req_write, req_funct3, req_address, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );

  modport master (
    output req_valid, req_write, req_funct3, req_address, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-addressed RAM (read-modify-write
// for sub-word stores). Define MISALIGN_TRAP_EN to reject misaligned accesses.
module load_store_unit #(
  parameter int unsigned ADDRESS_LIMIT = 1024
) (
  input  logic               i_clock,
  input  logic               i_reset,
  load_store_unit_if.slave   bus,
  output logic [31:0]        o_mem_address,
  output logic [31:0]        o_mem_input_data,
  output logic               o_mem_should_write,
  input  logic [31:0]        i_mem_output_data
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_t;

  state_t      r_state;
  logic        r_ready;
  logic        r_resp_valid;
  logic        r_resp_error;
  logic [31:0] r_resp_rdata;
  logic        r_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_write;
  logic [2:0]  r_f3;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;

  logic        w_bad;
  logic        w_misalign;
  logic [31:0] w_merged;
  logic [31:0] w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
    w_misalign = (bus.req_funct3[1:0] == 2'b01 && bus.req_address[0]) ||
                 (bus.req_funct3[1:0] == 2'b10 && bus.req_address[1:0] != 2'b00);
`endif
    w_bad = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
            (bus.req_funct3 == 3'b111) ||
            (bus.req_funct3[2] && bus.req_write) ||
            (bus.req_address >= ADDRESS_LIMIT) || w_misalign;
  end

  // Lane select ignores address bits below the access size (half uses addr[1]).
  always_comb begin
    w_byte   = i_mem_output_data[{r_lane, 3'b000} +: 8];
    w_half   = i_mem_output_data[{r_lane[1], 4'b0000} +: 16];
    w_merged = i_mem_output_data;
    if (r_f3[1:0] == 2'b00) w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    else                    w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
    case (r_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = i_mem_output_data;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_rdata <= '0;
      r_we         <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_write      <= 1'b0;
      r_f3         <= '0;
      r_lane       <= '0;
      r_wdata      <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_we         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready      <= 1'b1;
          r_resp_error <= 1'b0;
          r_resp_rdata <= '0;
          if (bus.req_valid && r_ready) begin
            r_ready    <= 1'b0;
            r_write    <= bus.req_write;
            r_f3       <= bus.req_funct3;
            r_lane     <= bus.req_address[1:0];
            r_wdata    <= bus.req_wdata[15:0];
            r_mem_addr <= {bus.req_address[31:2], 2'b00};
            if (w_bad) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b1;
            end else begin
              r_state <= S_ACCESS;
              // Word store writes during ACCESS; no read needed.
              if (bus.req_write && bus.req_funct3[1:0] == 2'b10) begin
                r_we        <= 1'b1;
                r_mem_wdata <= bus.req_wdata;
              end
            end
          end
        end
        S_ACCESS: begin
          if (!r_write) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_load;
          end else if (r_f3[1:0] == 2'b10) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
          end else begin
            r_state     <= S_WRITE;
            r_we        <= 1'b1;
            r_mem_wdata <= w_merged;
          end
        end
        S_WRITE: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_ready      <= 1'b1;
          r_resp_rdata <= '0;
          r_resp_error <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready      = r_ready;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_rdata     = r_resp_rdata;
  assign bus.resp_error     = r_resp_error;
  assign o_mem_address      = r_mem_addr;
  assign o_mem_input_data   = r_mem_wdata;
  // Reset asserted mid-store must never reach the RAM's negedge commit.
  assign o_mem_should_write = r_we && !i_reset;

endmodule
